// File: rtl/alarm_display_pkg.sv
// rtl/alarm_display_pkg.sv - shared ASCII constants, alarm state type and BCD conversion
package alarm_display_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_ONE   = 8'h31;
    localparam logic [7:0] ASCII_TWO   = 8'h32;
    localparam logic [7:0] ASCII_THREE = 8'h33;
    localparam logic [7:0] ASCII_FOUR  = 8'h34;
    localparam logic [7:0] ASCII_FIVE  = 8'h35;
    localparam logic [7:0] ASCII_SIX   = 8'h36;
    localparam logic [7:0] ASCII_SEVEN = 8'h37;
    localparam logic [7:0] ASCII_EIGHT = 8'h38;
    localparam logic [7:0] ASCII_NINE  = 8'h39;
    localparam logic [7:0] ASCII_ERROR = 8'h3A;
    localparam logic [7:0] ASCII_BLANK = 8'h20;

    typedef enum logic [1:0] {
        IDLE,
        RINGING,
        ACKED
    } alarm_state_t;

    // Non-decimal nibbles render as ':' so a corrupt BCD digit is visible on the display
    function automatic logic [7:0] bcd_to_ascii(input logic [3:0] bcd);
        return (bcd <= 4'd9) ? (ASCII_ZERO + {4'd0, bcd}) : ASCII_ERROR;
    endfunction

endpackage

// File: rtl/alarm_display_ctrl_digit.sv
// rtl/alarm_display_ctrl_digit.sv - single combinational BCD digit to ASCII converter
module bcd_ascii_digit
    import alarm_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] ascii
);

    assign ascii = bcd_to_ascii(bcd);

endmodule

// File: rtl/alarm_display_ctrl.sv
// rtl/alarm_display_ctrl.sv - multi-digit alarm display: source select, blink, scan and alarm FSM
module alarm_display_ctrl
    import alarm_display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_DIV    = 12500000,
    parameter int ALARM_CYCLES = 600000000
)
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      show_a,
    input  logic                      show_new_time,
    input  logic                      alarm_en,
    input  logic                      stop_alarm,
    input  logic [4*NUM_DIGITS-1:0]   alarm_time,
    input  logic [4*NUM_DIGITS-1:0]   current_time,
    input  logic [4*NUM_DIGITS-1:0]   key,
    output logic                      sound_alarm,
    output logic [8*NUM_DIGITS-1:0]   display_time,
    output logic [NUM_DIGITS-1:0]     scan_sel,
    output logic [7:0]                scan_char
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam int RING_W  = $clog2(ALARM_CYCLES);
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    logic [4*NUM_DIGITS-1:0] src_bcd;
    logic [8*NUM_DIGITS-1:0] ascii_all;
    logic [8*NUM_DIGITS-1:0] disp_next;
    logic [SCAN_W-1:0]       scan_cnt;
    logic [IDX_W-1:0]        scan_idx;
    logic [IDX_W-1:0]        idx_next;
    logic                    scan_tc;
    logic [BLINK_W-1:0]      blink_cnt;
    logic                    blink_phase;
    logic [RING_W-1:0]       ring_cnt;
    logic                    match;
    alarm_state_t            state;

    always_comb begin
        src_bcd = current_time;
        if (show_new_time)
            src_bcd = key;
        else if (show_a)
            src_bcd = alarm_time;
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_ascii_digit u_digit (
            .bcd   (src_bcd[4*g +: 4]),
            .ascii (ascii_all[8*g +: 8])
        );
    end

    // Blanking only applies to the key entry; other sources show immediately when it ends
    always_comb begin
        disp_next = ascii_all;
        if (show_new_time && !blink_phase)
            disp_next = {NUM_DIGITS{ASCII_BLANK}};
    end

    always_comb begin
        scan_tc  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
        idx_next = scan_idx;
        if (scan_tc)
            idx_next = (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
    end

    assign match = alarm_en && (current_time == alarm_time);

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (!show_new_time) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + BLINK_W'(1);
        end
    end

    // scan_sel and scan_char are loaded from the same next-state values as display_time
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt     <= '0;
            scan_idx     <= '0;
            scan_sel     <= NUM_DIGITS'(1);
            scan_char    <= ASCII_BLANK;
            display_time <= {NUM_DIGITS{ASCII_BLANK}};
        end else begin
            scan_cnt     <= scan_tc ? '0 : scan_cnt + SCAN_W'(1);
            scan_idx     <= idx_next;
            scan_sel     <= NUM_DIGITS'(1) << idx_next;
            scan_char    <= disp_next[8*int'(idx_next) +: 8];
            display_time <= disp_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sound_alarm <= 1'b0;
            ring_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (match && stop_alarm) begin
                        state <= ACKED;
                    end else if (match) begin
                        state       <= RINGING;
                        sound_alarm <= 1'b1;
                        ring_cnt    <= '0;
                    end
                end
                RINGING: begin
                    if (stop_alarm || !alarm_en || ring_cnt == RING_W'(ALARM_CYCLES - 1)) begin
                        state       <= ACKED;
                        sound_alarm <= 1'b0;
                    end else begin
                        ring_cnt <= ring_cnt + RING_W'(1);
                    end
                end
                ACKED: begin
                    // Stay silent for the rest of the matching minute
                    if (current_time != alarm_time)
                        state <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    sound_alarm <= 1'b0;
                end
            endcase
        end
    end

endmodule
